// File: rtl/rgb_led_pwm.sv
// ---------------------------------------------------------------------------
// rgb_led_pwm
//   Multi-channel PWM driver for active-low LED pins. Each channel has a duty
//   level and a mode (OFF, SOLID, BLINK, BREATHE). Writes arrive over a
//   valid/ready port into a one-entry pending slot. The slot is committed to
//   the channel's active settings on a frame_tick, so a PWM frame never sees
//   a half-applied change.
//
//   Optional build macro: LED_GAMMA_EN
//     defined   : effective duty e is squared, e' = (e*e) >> PWM_BITS
//     undefined : effective duty used linearly
//
// Ports
//   clk48      in   system clock
//   rst        in   asynchronous reset, active-high
//   cfg_valid  in   config write request
//   cfg_ready  out  pending slot free; write accepted on cfg_valid & cfg_ready
//   cfg_chan   in   target channel (indices >= CHANNELS are dropped at commit)
//   cfg_mode   in   0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE
//   cfg_duty   in   duty level
//   led_n      out  LED drive, active-low (0 = lit)
//   frame_tick out  one-cycle pulse the cycle after each PWM frame wrap
// ---------------------------------------------------------------------------
module rgb_led_pwm #(
    parameter int CHANNELS   = 3,
    parameter int CH_BITS    = 2,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 188,
    parameter int BLINK_BITS = 8
) (
    input  logic                clk48,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_BITS-1:0]  cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] led_n,
    output logic                frame_tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    // Timebase
    logic [PS_W-1:0]       r_presc;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic                  r_frame_tick;
    logic [BLINK_BITS-1:0] r_frame_cnt;
    logic [PWM_BITS-1:0]   r_ramp;
    logic                  r_ramp_down;

    // Active per-channel settings and the duty latched for the running frame
    mode_t                 r_mode [CHANNELS];
    logic [PWM_BITS-1:0]   r_duty [CHANNELS];
    logic [PWM_BITS-1:0]   r_eff  [CHANNELS];

    // Pending configuration slot
    logic                  r_slot_full;
    logic [CH_BITS-1:0]    r_slot_chan;
    mode_t                 r_slot_mode;
    logic [PWM_BITS-1:0]   r_slot_duty;

    logic [CHANNELS-1:0]   r_led_n;

    logic                  w_step;
    logic                  w_wrap;
    logic                  w_accept;
    logic                  w_blink_on;
    logic [CHANNELS-1:0][PWM_BITS-1:0] w_eff;

    assign w_step     = (r_presc == PS_LAST);
    assign w_wrap     = w_step && (r_pwm_cnt == PWM_MAX);
    assign w_accept   = cfg_valid && !r_slot_full;
    assign w_blink_on = r_frame_cnt[BLINK_BITS-1];

    assign cfg_ready  = !r_slot_full;
    assign frame_tick = r_frame_tick;
    assign led_n      = r_led_n;

    // Mode selection, then optional square-law correction.
    function automatic logic [PWM_BITS-1:0] f_eff(
        input mode_t               m,
        input logic [PWM_BITS-1:0] duty,
        input logic [PWM_BITS-1:0] ramp,
        input logic                blink_on
    );
        logic [2*PWM_BITS-1:0] prod;
        logic [PWM_BITS-1:0]   e;
`ifdef LED_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
`endif
        prod = {{PWM_BITS{1'b0}}, ramp} * {{PWM_BITS{1'b0}}, duty};
        case (m)
            MODE_OFF:     e = '0;
            MODE_SOLID:   e = duty;
            MODE_BLINK:   e = blink_on ? duty : '0;
            MODE_BREATHE: e = prod[2*PWM_BITS-1:PWM_BITS];
            default:      e = '0;
        endcase
`ifdef LED_GAMMA_EN
        sq = {{PWM_BITS{1'b0}}, e} * {{PWM_BITS{1'b0}}, e};
        e  = sq[2*PWM_BITS-1:PWM_BITS];
`endif
        return e;
    endfunction

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_eff
            assign w_eff[gi] = f_eff(r_mode[gi], r_duty[gi], r_ramp, w_blink_on);
        end
    endgenerate

    // Prescaler, PWM counter, frame pulse, blink counter and breathe ramp.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_pwm_cnt    <= '0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
            r_ramp       <= '0;
            r_ramp_down  <= 1'b0;
        end else begin
            if (w_step) begin
                r_presc   <= '0;
                r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            end else begin
                r_presc   <= r_presc + PS_W'(1);
            end
            r_frame_tick <= w_wrap;
            if (r_frame_tick) begin
                r_frame_cnt <= r_frame_cnt + BLINK_BITS'(1);
                // Triangle: direction flips on the step that lands on an end
                // value, so both 0 and PWM_MAX are each held for one frame.
                if (!r_ramp_down) begin
                    r_ramp <= r_ramp + PWM_ONE;
                    if (r_ramp == PWM_MAX - PWM_ONE) begin
                        r_ramp_down <= 1'b1;
                    end
                end else begin
                    r_ramp <= r_ramp - PWM_ONE;
                    if (r_ramp == PWM_ONE) begin
                        r_ramp_down <= 1'b0;
                    end
                end
            end
        end
    end

    // Pending slot: accept when empty, commit on frame_tick. An accept on the
    // frame_tick cycle itself only fills the slot; its commit is a frame later.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_slot_full <= 1'b0;
            r_slot_chan <= '0;
            r_slot_mode <= MODE_OFF;
            r_slot_duty <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_mode[c] <= MODE_OFF;
                r_duty[c] <= '0;
            end
        end else begin
            if (r_frame_tick && r_slot_full) begin
                // Out-of-range channel numbers match nothing and are dropped.
                for (int c = 0; c < CHANNELS; c++) begin
                    if (r_slot_chan == CH_BITS'(c)) begin
                        r_mode[c] <= r_slot_mode;
                        r_duty[c] <= r_slot_duty;
                    end
                end
                r_slot_full <= 1'b0;
            end
            if (w_accept) begin
                r_slot_full <= 1'b1;
                r_slot_chan <= cfg_chan;
                r_slot_mode <= mode_t'(cfg_mode);
                r_slot_duty <= cfg_duty;
            end
        end
    end

    // The effective duty is latched on the same edge that returns pwm_cnt to
    // zero, so every step of a frame compares against one value. A commit
    // therefore shows up from the first step of the following frame.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            r_led_n <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                r_eff[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wrap) begin
                    r_eff[c] <= w_eff[c];
                end
                r_led_n[c] <= !(r_pwm_cnt < r_eff[c]);
            end
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// ---------------------------------------------------------------------------
// tb_rgb_led_pwm
//   Bench for rgb_led_pwm with PRESCALE=1, PWM_BITS=8, BLINK_BITS=2, 3 channels.
//   A reference model built on elapsed-cycle arithmetic predicts led_n,
//   cfg_ready and frame_tick every cycle; per-frame lit counts observed on the
//   pins pin the model down with hand-computed values.
// ---------------------------------------------------------------------------
module tb_rgb_led_pwm;

    localparam int CH    = 3;
    localparam int PB    = 8;
    localparam int BB    = 2;
    localparam int FRAME = 1 << PB;
    localparam int NFR   = 400;

    logic       clk48 = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_chan = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] cfg_duty = 8'd0;
    logic [2:0] led_n;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;
    int nprint = 0;

    rgb_led_pwm #(
        .CHANNELS   (CH),
        .CH_BITS    (2),
        .PWM_BITS   (PB),
        .PRESCALE   (1),
        .BLINK_BITS (BB)
    ) dut (
        .clk48      (clk48),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_mode   (cfg_mode),
        .cfg_duty   (cfg_duty),
        .led_n      (led_n),
        .frame_tick (frame_tick)
    );

    initial forever #5 clk48 = ~clk48;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (nprint < 40) $display("FAIL %s: got %0d expected %0d", name, got, exp);
            nprint++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int g(input int e);
`ifdef LED_GAMMA_EN
        return (e * e) >> PB;
`else
        return e;
`endif
    endfunction

    // Ramp value after n frame ticks: triangle 0..255..0 with period 510.
    function automatic int ramp_of(input int n);
        int p;
        p = n % (2 * (FRAME - 1));
        return (p <= FRAME - 1) ? p : 2 * (FRAME - 1) - p;
    endfunction

    function automatic int model_eff(input int mode, input int duty, input int n);
        int e;
        case (mode)
            1:       e = duty;
            2:       e = ((n % (1 << BB)) >= (1 << (BB - 1))) ? duty : 0;
            3:       e = (ramp_of(n) * duty) >> PB;
            default: e = 0;
        endcase
        return g(e);
    endfunction

    int         m_t, m_ticks;
    int         act_mode [CH];
    int         act_duty [CH];
    int         m_eff [CH];
    bit         slot_full;
    int         slot_ch, slot_mode, slot_duty;
    logic [2:0] exp_led;
    logic       exp_ready, exp_tick;

    task automatic model_reset();
        m_t = 0; m_ticks = 0; slot_full = 0;
        slot_ch = 0; slot_mode = 0; slot_duty = 0;
        for (int c = 0; c < CH; c++) begin
            act_mode[c] = 0; act_duty[c] = 0; m_eff[c] = 0;
        end
        exp_led = 3'b111; exp_ready = 1'b1; exp_tick = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk48 or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                int pwm;
                logic [2:0] nl;
                bit acc, tk;
                pwm = m_t % FRAME;
                for (int c = 0; c < CH; c++) nl[c] = !(pwm < m_eff[c]);
                tk  = (m_t > 0) && (pwm == 0);
                acc = cfg_valid && !slot_full;
                if (tk) begin
                    if (slot_full && slot_ch < CH) begin
                        act_mode[slot_ch] = slot_mode;
                        act_duty[slot_ch] = slot_duty;
                    end
                    slot_full = 0;
                    m_ticks++;
                end
                if (acc) begin
                    slot_full = 1;
                    slot_ch   = int'(cfg_chan);
                    slot_mode = int'(cfg_mode);
                    slot_duty = int'(cfg_duty);
                end
                if (pwm == FRAME - 1)
                    for (int c = 0; c < CH; c++) m_eff[c] = model_eff(act_mode[c], act_duty[c], m_ticks);
                m_t++;
                exp_led   = nl;
                exp_ready = !slot_full;
                exp_tick  = ((m_t % FRAME) == 0);
            end
        end
    end

    // ---------------- compare + observation ----------------
    int frame_idx = 0;
    int lit_cnt [CH];
    int acc_cnt = 0;
    int frame_lit [CH][NFR];
    int frame_acc [NFR];

    initial begin
        for (int c = 0; c < CH; c++) lit_cnt[c] = 0;
        forever begin
            @(negedge clk48);
            check("led_n",      32'(led_n),      32'(exp_led));
            check("cfg_ready",  32'(cfg_ready),  32'(exp_ready));
            check("frame_tick", 32'(frame_tick), 32'(exp_tick));
            if (rst) begin
                frame_idx = 0; acc_cnt = 0;
                for (int c = 0; c < CH; c++) lit_cnt[c] = 0;
            end else begin
                for (int c = 0; c < CH; c++) lit_cnt[c] += (led_n[c] == 1'b0) ? 1 : 0;
                if (cfg_valid && cfg_ready) acc_cnt++;
                if (frame_tick) begin
                    if (frame_idx < NFR) begin
                        for (int c = 0; c < CH; c++) frame_lit[c][frame_idx] = lit_cnt[c];
                        frame_acc[frame_idx] = acc_cnt;
                    end
                    frame_idx++;
                    acc_cnt = 0;
                    for (int c = 0; c < CH; c++) lit_cnt[c] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(posedge clk48); #2;
        rst = 1'b1; cfg_valid = 1'b0;
        repeat (3) @(posedge clk48);
        #2;
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int duty);
        int n;
        bit done;
        n = 0; done = 0;
        cfg_chan = 2'(ch); cfg_mode = 2'(mode); cfg_duty = 8'(duty); cfg_valid = 1'b1;
        while (!done && n < 2000) begin
            @(negedge clk48);
            done = cfg_ready;
            @(posedge clk48); #2;
            n++;
        end
        cfg_valid = 1'b0;
        check("cfg_write_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frame_idx < target && n < 90000) begin
            @(posedge clk48);
            n++;
        end
        #2;
        check("wait_frames", 32'(frame_idx >= target), 32'd1);
    endtask

    task automatic rand_inputs(input bit force_valid);
        int r;
        cfg_valid = force_valid ? 1'b1 : ($urandom_range(0, 9) < 7);
        cfg_chan  = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 3);
        cfg_duty  = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p, n;

        // Reset values while reset is held.
        @(posedge clk48); #2;
        repeat (2) @(posedge clk48);
        #2;
        check("reset_led_n",      32'(led_n),      32'd7);
        check("reset_cfg_ready",  32'(cfg_ready),  32'd1);
        check("reset_frame_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        // SOLID, edge duties, BLINK, out-of-range channel.
        cfg_write(0, 1, 64);
        cfg_write(1, 1, 255);
        cfg_write(2, 2, 255);
        cfg_write(3, 1, 200);
        cfg_write(1, 1, 0);
        wait_frames(11);
        check("solid64_f1",  32'(frame_lit[0][1]), 32'd0);
        check("solid64_f2",  32'(frame_lit[0][2]), 32'(g(64)));
        check("solid64_f9",  32'(frame_lit[0][9]), 32'(g(64)));
        check("ch1_f2",      32'(frame_lit[1][2]), 32'd0);
        check("duty255_f3",  32'(frame_lit[1][3]), 32'(g(255)));
        check("duty255_f5",  32'(frame_lit[1][5]), 32'(g(255)));
        check("duty0_f7",    32'(frame_lit[1][7]), 32'd0);
        check("blink_f3",    32'(frame_lit[2][3]), 32'd0);
        check("blink_f4",    32'(frame_lit[2][4]), 32'(g(255)));
        check("blink_f5",    32'(frame_lit[2][5]), 32'd0);
        check("blink_f6",    32'(frame_lit[2][6]), 32'd0);
        check("blink_f7",    32'(frame_lit[2][7]), 32'(g(255)));
        check("blink_f8",    32'(frame_lit[2][8]), 32'(g(255)));
        check("blink_f9",    32'(frame_lit[2][9]), 32'd0);
        $display("directed solid/edge/blink section at frame %0d", frame_idx);

        // Reset mid-cycle with a write waiting in the slot.
        cfg_write(0, 1, 255);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_led_n",      32'(led_n),      32'd7);
        check("midrst_cfg_ready",  32'(cfg_ready),  32'd1);
        check("midrst_frame_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(posedge clk48);
        #2;
        rst = 1'b0;
        wait_frames(4);
        for (int f = 1; f < 4; f++) check("lost_write", 32'(frame_lit[0][f]), 32'd0);
        $display("mid-frame reset section at frame %0d", frame_idx);

        // BREATHE through the ramp peak.
        apply_reset();
        cfg_write(0, 3, 255);
        wait_frames(260);
        check("breathe_f1",   32'(frame_lit[0][1]),   32'd0);
        check("breathe_f2",   32'(frame_lit[0][2]),   32'(g(0)));
        check("breathe_f3",   32'(frame_lit[0][3]),   32'(g(1)));
        check("breathe_f4",   32'(frame_lit[0][4]),   32'(g(2)));
        check("breathe_f5",   32'(frame_lit[0][5]),   32'(g(3)));
        check("breathe_f255", 32'(frame_lit[0][255]), 32'(g(253)));
        check("breathe_f256", 32'(frame_lit[0][256]), 32'(g(254)));
        check("breathe_f257", 32'(frame_lit[0][257]), 32'(g(253)));
        check("breathe_f258", 32'(frame_lit[0][258]), 32'(g(252)));
        check("breathe_ch1",  32'(frame_lit[1][100]), 32'd0);
        $display("breathe section at frame %0d", frame_idx);

        // Random writes, then cfg_valid held high continuously.
        repeat (6 * FRAME) begin
            rand_inputs(1'b0);
            @(posedge clk48); #2;
        end
        p = frame_idx;
        n = 0;
        while (frame_idx < p + 6 && n < 3000) begin
            rand_inputs(1'b1);
            @(posedge clk48); #2;
            n++;
        end
        cfg_valid = 1'b0;
        check("held_valid_done", 32'(frame_idx >= p + 6), 32'd1);
        for (int f = p + 1; f < p + 6; f++) check("one_accept_per_frame", 32'(frame_acc[f]), 32'd1);
        $display("random section ended at frame %0d", frame_idx);

        repeat (4) @(posedge clk48);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
